// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared state type, default sizes and mask helper for the sequence detector
package seq_ctrl_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TO_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } seq_state_e;

  // Low `len` bits set; wide enough for any MAX_LEN up to 32.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// rtl/seq_window_match.sv - serial history shift register, fill counter and masked pattern compare
module seq_window_match
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               window_full,
  output logic               hit
);

  logic [MAX_LEN-2:0] sr;
  logic [MAX_LEN-1:0] window;
  logic [LEN_W-1:0]   fill_cnt;
  logic [LEN_W:0]     fill_p1;

  // The incoming bit is part of the window evaluated on this edge.
  assign window      = {sr, in};
  assign fill_p1     = {1'b0, fill_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign window_full = (fill_p1 >= {1'b0, len});
  assign hit         = ((32'(window) ^ 32'(pattern)) & len_mask(32'(len))) == 32'd0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr       <= '0;
      fill_cnt <= '0;
    end else if (shift_en) begin
      sr <= window[MAX_LEN-2:0];
      if (fill_cnt != LEN_W'(MAX_LEN)) fill_cnt <= fill_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with match target and timeout
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               timeout,
  output logic               cfg_err
);

  seq_state_e state, state_d;

  logic [MAX_LEN-1:0] sh_pattern;
  logic [LEN_W-1:0]   sh_len;
  logic               sh_overlap;
  logic [CNT_W-1:0]   sh_target;
  logic [TO_W-1:0]    sh_timeout;

  logic [TO_W-1:0]  timer, timer_d, timer_p1;
  logic [CNT_W-1:0] cnt_d, cnt_p1;
  logic             match_d, done_d, timeout_d, cfg_err_d;
  logic             cfg_load, win_clr, shift_en;
  logic             window_full, hit, hit_now, expired, cfg_bad;

  seq_window_match #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clr        (win_clr),
    .shift_en   (shift_en),
    .in         (in),
    .len        (sh_len),
    .pattern    (sh_pattern),
    .window_full(window_full),
    .hit        (hit)
  );

  assign timer_p1 = timer + 1'b1;
  assign cnt_p1   = match_cnt + 1'b1;
  assign hit_now  = window_full & hit;
  assign expired  = (sh_timeout != '0) && (timer_p1 == sh_timeout);
  assign cfg_bad  = (sh_len == '0) || (sh_len > LEN_W'(MAX_LEN)) || (sh_target == '0);
  assign busy     = (state != IDLE);

  always_comb begin
    state_d   = state;
    match_d   = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cfg_err_d = 1'b0;
    cnt_d     = match_cnt;
    timer_d   = timer;
    cfg_load  = 1'b0;
    win_clr   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        cfg_load = cfg_we;
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cnt_d   = '0;
            timer_d = '0;
            win_clr = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL, HUNT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          timer_d  = timer_p1;
          if (hit_now) begin
            match_d = 1'b1;
            cnt_d   = cnt_p1;
          end
          // done outranks timeout; a non-final match on the expiry edge still counts
          if (hit_now && (cnt_p1 == sh_target)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else if (hit_now && !sh_overlap) begin
            win_clr = 1'b1;
            state_d = FILL;
          end else if (window_full) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      match     <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      timer     <= '0;
    end else begin
      state     <= state_d;
      match     <= match_d;
      done      <= done_d;
      timeout   <= timeout_d;
      cfg_err   <= cfg_err_d;
      match_cnt <= cnt_d;
      timer     <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pattern <= '0;
      sh_len     <= '0;
      sh_overlap <= 1'b0;
      sh_target  <= '0;
      sh_timeout <= '0;
    end else if (cfg_load) begin
      sh_pattern <= cfg_pattern;
      sh_len     <= cfg_len;
      sh_overlap <= cfg_overlap;
      sh_target  <= cfg_target;
      sh_timeout <= cfg_timeout;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench with a bit-history reference model for seq_detect_ctrl
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic [TO_W-1:0]    cfg_timeout = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               in = 1'b0;
  logic               busy, match, done, timeout, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  seq_detect_ctrl #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .in(in), .busy(busy), .match(match),
    .match_cnt(match_cnt), .done(done), .timeout(timeout), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at_edge;
    bit match;
    bit done;
    bit tmo;
    bit err;
    int cnt;
    bit busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  edge_no = 0;
  bit  stim[$];

  // reference model: shadow config plus the raw bit history since the window was last cleared
  bit                 m_busy = 0;
  int                 m_cnt = 0;
  int                 m_timer = 0;
  bit                 m_hist[$];
  logic [MAX_LEN-1:0] m_pat = '0;
  int                 m_len = 0;
  bit                 m_ovl = 0;
  int                 m_tgt = 0;
  int                 m_to = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic model_step();
    ev_t e;
    bit  hit;
    bit  expd;
    e.at_edge = edge_no + 1;
    e.match = 0; e.done = 0; e.tmo = 0; e.err = 0; e.cnt = 0; e.busy = 0;
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_timer = 0; m_hist.delete();
      m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0; m_to = 0;
      return;
    end
    if (!m_busy) begin
      if (start) begin
        if (m_len == 0 || m_len > MAX_LEN || m_tgt == 0) begin
          e.err = 1; e.cnt = m_cnt; e.busy = 0;
          exp_q.push_back(e);
        end else begin
          m_busy = 1; m_cnt = 0; m_timer = 0; m_hist.delete();
        end
      end
      if (cfg_we) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_tgt = int'(cfg_target); m_to = int'(cfg_timeout);
      end
      return;
    end
    if (abort) begin
      m_busy = 0;
      return;
    end
    m_timer++;
    m_hist.push_back(in);
    if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
    hit = 0;
    if (m_hist.size() >= m_len) begin
      hit = 1;
      for (int i = 0; i < m_len; i++)
        if (m_hist[m_hist.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
    end
    expd = (m_to != 0) && (m_timer == m_to);
    if (hit) m_cnt++;
    if (hit && m_cnt == m_tgt) begin
      e.match = 1; e.done = 1; m_busy = 0;
    end else if (expd) begin
      e.match = hit; e.tmo = 1; m_busy = 0;
    end else if (hit) begin
      e.match = 1;
      if (!m_ovl) m_hist.delete();
    end
    if (e.match || e.tmo) begin
      e.cnt = m_cnt; e.busy = m_busy;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit s, input bit ab, input bit we, input bit b);
    start = s; abort = ab; cfg_we = we; in = b;
    model_step();
    @(posedge clk);
    edge_no++;
    #1;
    chk("busy", busy, m_busy);
    chk("match_cnt", match_cnt, m_cnt);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input int t, input int to);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
    cfg_target = CNT_W'(t); cfg_timeout = TO_W'(to);
    step(0, 0, 1, rb());
  endtask

  task automatic run_stim(input int tail);
    step(1, 0, 0, rb());
    foreach (stim[i]) step(0, 0, 0, stim[i]);
    for (int i = 0; i < tail; i++) step(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].at_edge < edge_no) begin
      chk("missed_event_edge", edge_no, exp_q[0].at_edge);
      void'(exp_q.pop_front());
    end
    if (match || done || timeout || cfg_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {match, done, timeout, cfg_err}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_edge", edge_no, e.at_edge);
        chk("ev_match", match, e.match);
        chk("ev_done", done, e.done);
        chk("ev_timeout", timeout, e.tmo);
        chk("ev_cfg_err", cfg_err, e.err);
        chk("ev_match_cnt", match_cnt, e.cnt);
        chk("ev_busy", busy, e.busy);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_no);
    $fatal(1);
  end

  initial begin : driver
    rst = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 0;
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // start with no configuration loaded
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    load_cfg(8'b1011, 4, 1, 2, 0);
    stim = '{1, 0, 1, 1, 0, 1, 1};
    run_stim(3);

    load_cfg(8'b1011, 4, 0, 2, 10);
    run_stim(8);

    load_cfg(8'b11, 2, 1, 3, 0);
    stim = '{1, 1, 1, 1};
    run_stim(2);
    load_cfg(8'b11, 2, 0, 2, 0);
    run_stim(2);

    load_cfg(8'b1, 1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    // abort after first match; cfg_we mid-run must not disturb the shadow pattern
    load_cfg(8'b101, 3, 1, 5, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    cfg_pattern = 8'b010;
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);

    load_cfg(8'b1, 1, 0, 1, 4);
    stim = '{0, 0, 0, 1};
    run_stim(2);

    // reset mid-run
    load_cfg(8'b110, 3, 1, 9, 0);
    stim = '{1, 1, 0};
    step(1, 0, 0, 0);
    foreach (stim[i]) step(0, 0, 0, stim[i]);
    rst = 1;
    step(0, 0, 0, 1);
    rst = 0;
    chk("midrst_match", match, 0);
    step(1, 0, 0, 0);

    for (int r = 0; r < 60; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len = (sel == 0) ? LEN_W'($urandom_range(9, 15)) :
                (sel == 1) ? LEN_W'(0) :
                (sel < 5)  ? LEN_W'($urandom_range(1, MAX_LEN)) : LEN_W'($urandom_range(1, 3));
      cfg_overlap = rb();
      cfg_target = CNT_W'($urandom_range(0, 5));
      cfg_timeout = (rb()) ? TO_W'(0) : TO_W'($urandom_range(1, 40));
      step(0, 0, 1, rb());
      step(1, 0, 0, rb());
      for (int c = 0; c < 80 && m_busy; c++) begin
        bit we;
        we = ($urandom_range(0, 19) == 0);
        if (we) cfg_pattern = MAX_LEN'($urandom);
        step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, we, rb());
      end
      if (m_busy) step(0, 1, 0, rb());
      if (r % 17 == 5) begin
        rst = 1;
        step(0, 0, 0, rb());
        rst = 0;
      end
      step(0, 0, 0, rb());
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
